maze_move_ctrl: RTL and testbench

Motion executor answering the Q-table exploit controller's move requests. It accepts a requested next maze cell and checks that the cell is adjacent to the current one. It turns the robot to face that cell, drives one cell forward, then updates the current cell and pulses `move_complete`. It sits between the Q-learning/exploit logic and the motor drivers, and owns the authoritative `maze_state` register.

---
 rtl/maze_pkg.sv | 23 ++
 rtl/maze_adjacency.sv | 48 ++++
 rtl/maze_move_ctrl.sv | 165 ++++++++++++++++
 tb/tb_maze_move_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared cell/heading/FSM types and default maze size for the move controller
package maze_pkg;
    localparam int MAZE_COLS = 6;
    localparam int MAZE_ROWS = 6;

    typedef logic [5:0] cell_t;

    typedef enum logic [1:0] {
        N = 2'd0,
        E = 2'd1,
        S = 2'd2,
        W = 2'd3
    } heading_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_TURN,
        ST_DRIVE,
        ST_DONE,
        ST_ERR
    } move_fsm_t;
endpackage

// File: rtl/maze_adjacency.sv
// rtl/maze_adjacency.sv - combinational neighbour check: range, row-wrap and desired heading
module maze_adjacency
    import maze_pkg::*;
#(
    parameter int COLS = MAZE_COLS,
    parameter int ROWS = MAZE_ROWS
) (
    input  logic [5:0] i_cur,
    input  logic [5:0] i_tgt,
    output logic       o_valid,
    output logic       o_same,
    output heading_t   o_heading
);
    localparam int NCELLS = ROWS * COLS;

    logic [31:0] w_cur;
    logic [31:0] w_tgt;
    logic [31:0] w_col;
    logic        w_in_range;
    logic        w_n;
    logic        w_e;
    logic        w_s;
    logic        w_w;

    assign w_cur      = 32'(i_cur);
    assign w_tgt      = 32'(i_tgt);
    assign w_col      = w_cur % 32'(COLS);
    assign w_in_range = (w_tgt < 32'(NCELLS));

    // East/west moves are only legal when they stay inside the current row.
    assign w_n = (w_cur >= 32'(COLS)) && (w_tgt == w_cur - 32'(COLS));
    assign w_s = (w_tgt == w_cur + 32'(COLS));
    assign w_e = (w_col != 32'(COLS - 1)) && (w_tgt == w_cur + 32'd1);
    assign w_w = (w_col != 32'd0) && (w_tgt + 32'd1 == w_cur);

    assign o_same  = w_in_range && (w_tgt == w_cur);
    assign o_valid = w_in_range && (o_same || w_n || w_e || w_s || w_w);

    always_comb begin
        o_heading = N;
        if (w_e)
            o_heading = E;
        else if (w_s)
            o_heading = S;
        else if (w_w)
            o_heading = W;
    end
endmodule

// File: rtl/maze_move_ctrl.sv
// rtl/maze_move_ctrl.sv - executes one-cell maze moves: check, turn in 90 degree quanta, drive, report
module maze_move_ctrl
    import maze_pkg::*;
#(
    parameter int COLS         = MAZE_COLS,
    parameter int ROWS         = MAZE_ROWS,
    parameter int TURN_CYCLES  = 50000,
    parameter int DRIVE_CYCLES = 200000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_timer_start,
    input  logic [5:0] i_next_state,
    input  logic       i_load_start,
    input  logic [5:0] i_start_state,
    output logic [5:0] o_maze_state,
    output logic       o_move_complete,
    output logic       o_move_error,
    output logic [1:0] o_heading,
    output logic       o_motor_l_en,
    output logic       o_motor_r_en,
    output logic       o_motor_l_dir,
    output logic       o_motor_r_dir,
    output logic       o_busy
);
    localparam int MAXC = (TURN_CYCLES > DRIVE_CYCLES) ? TURN_CYCLES : DRIVE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    move_fsm_t   r_state;
    cell_t       r_maze_state;
    cell_t       r_target;
    heading_t    r_heading;
    heading_t    r_desired;
    logic        r_turn_left;
    logic [CW-1:0] r_cnt;
    logic        r_move_complete;
    logic        r_move_error;
    logic        r_l_en;
    logic        r_r_en;
    logic        r_l_dir;
    logic        r_r_dir;
    logic        r_busy;

    logic        w_valid;
    logic        w_same;
    heading_t    w_desired;
    logic [1:0]  w_turns;
    logic [1:0]  w_hd_step;

    maze_adjacency #(.COLS(COLS), .ROWS(ROWS)) u_adj (
        .i_cur     (r_maze_state),
        .i_tgt     (r_target),
        .o_valid   (w_valid),
        .o_same    (w_same),
        .o_heading (w_desired)
    );

    assign w_turns   = w_desired - r_heading;
    assign w_hd_step = r_turn_left ? (r_heading - 2'd1) : (r_heading + 2'd1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_maze_state    <= '0;
            r_target        <= '0;
            r_heading       <= N;
            r_desired       <= N;
            r_turn_left     <= 1'b0;
            r_cnt           <= '0;
            r_move_complete <= 1'b0;
            r_move_error    <= 1'b0;
            r_l_en          <= 1'b0;
            r_r_en          <= 1'b0;
            r_l_dir         <= 1'b0;
            r_r_dir         <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_move_complete <= 1'b0;
            r_move_error    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_load_start) begin
                        r_maze_state <= i_start_state;
                        r_heading    <= N;
                    end else if (i_timer_start) begin
                        r_target <= i_next_state;
                        r_state  <= ST_CHECK;
                        r_busy   <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_cnt       <= '0;
                    r_desired   <= w_desired;
                    // A half turn uses two right quanta; only a 3-step delta turns left.
                    r_turn_left <= (w_turns == 2'd3);
                    if (!w_valid) begin
                        r_state      <= ST_ERR;
                        r_move_error <= 1'b1;
                    end else if (w_same) begin
                        r_state         <= ST_DONE;
                        r_maze_state    <= r_target;
                        r_move_complete <= 1'b1;
                    end else if (w_turns != 2'd0) begin
                        r_state <= ST_TURN;
                        r_l_en  <= 1'b1;
                        r_r_en  <= 1'b1;
                        r_l_dir <= (w_turns != 2'd3);
                        r_r_dir <= (w_turns == 2'd3);
                    end else begin
                        r_state <= ST_DRIVE;
                        r_l_en  <= 1'b1;
                        r_r_en  <= 1'b1;
                        r_l_dir <= 1'b1;
                        r_r_dir <= 1'b1;
                    end
                end
                ST_TURN: begin
                    if (r_cnt == CW'(TURN_CYCLES - 1)) begin
                        r_cnt     <= '0;
                        r_heading <= heading_t'(w_hd_step);
                        if (w_hd_step == r_desired) begin
                            r_state <= ST_DRIVE;
                            r_l_dir <= 1'b1;
                            r_r_dir <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == CW'(DRIVE_CYCLES - 1)) begin
                        r_cnt           <= '0;
                        r_state         <= ST_DONE;
                        r_maze_state    <= r_target;
                        r_move_complete <= 1'b1;
                        r_l_en          <= 1'b0;
                        r_r_en          <= 1'b0;
                        r_l_dir         <= 1'b0;
                        r_r_dir         <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_maze_state    = r_maze_state;
    assign o_move_complete = r_move_complete;
    assign o_move_error    = r_move_error;
    assign o_heading       = r_heading;
    assign o_motor_l_en    = r_l_en;
    assign o_motor_r_en    = r_r_en;
    assign o_motor_l_dir   = r_l_dir;
    assign o_motor_r_dir   = r_r_dir;
    assign o_busy          = r_busy;
endmodule

// File: tb/tb_maze_move_ctrl.sv
// tb/tb_maze_move_ctrl.sv - directed self-checking bench for maze_move_ctrl (TURN=4, DRIVE=8, 6x6)
module tb_maze_move_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       timer_start;
    logic [5:0] next_state;
    logic       load_start;
    logic [5:0] start_state;
    logic [5:0] maze_state;
    logic       move_complete;
    logic       move_error;
    logic [1:0] heading;
    logic       motor_l_en;
    logic       motor_r_en;
    logic       motor_l_dir;
    logic       motor_r_dir;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         m_lat;
    int         m_fwd;
    int         m_right;
    int         m_left;
    int         m_other;
    logic       m_done;
    logic       m_err;
    logic [5:0] m_maze;
    logic       m_busy_after;

    maze_move_ctrl #(
        .COLS(6), .ROWS(6), .TURN_CYCLES(4), .DRIVE_CYCLES(8)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_timer_start   (timer_start),
        .i_next_state    (next_state),
        .i_load_start    (load_start),
        .i_start_state   (start_state),
        .o_maze_state    (maze_state),
        .o_move_complete (move_complete),
        .o_move_error    (move_error),
        .o_heading       (heading),
        .o_motor_l_en    (motor_l_en),
        .o_motor_r_en    (motor_r_en),
        .o_motor_l_dir   (motor_l_dir),
        .o_motor_r_dir   (motor_r_dir),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] s);
        load_start  = 1'b1;
        start_state = s;
        tick();
        load_start = 1'b0;
    endtask

    task automatic classify();
        if (motor_l_en && motor_r_en) begin
            if (motor_l_dir && motor_r_dir)       m_fwd++;
            else if (motor_l_dir && !motor_r_dir) m_right++;
            else if (!motor_l_dir && motor_r_dir) m_left++;
            else                                  m_other++;
        end else if (motor_l_en || motor_r_en) begin
            m_other++;
        end
    endtask

    // m_lat = n where the completion/error pulse is seen in cycle T+n.
    task automatic do_move(input logic [5:0] dst, input int inj_at);
        m_fwd = 0; m_right = 0; m_left = 0; m_other = 0;
        next_state  = dst;
        timer_start = 1'b1;
        tick();
        timer_start = 1'b0;
        m_lat = 1;
        while (!move_complete && !move_error && m_lat < 60) begin
            classify();
            if (m_lat == inj_at) begin
                timer_start = 1'b1;
                load_start  = 1'b1;
                next_state  = dst + 6'd1;
                start_state = 6'd3;
            end
            tick();
            timer_start = 1'b0;
            load_start  = 1'b0;
            m_lat++;
        end
        classify();
        m_done = move_complete;
        m_err  = move_error;
        m_maze = maze_state;
        tick();
        m_busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; timer_start = 1'b0; load_start = 1'b0;
        next_state = '0; start_state = '0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({maze_state, heading} !== 8'd0) begin
            errors++; $display("FAIL reset_state got maze=%0d hd=%0d want 0/0", maze_state, heading);
        end
        checks++;
        if ({motor_l_en, motor_r_en, motor_l_dir, motor_r_dir, move_complete, move_error, busy} !== 7'd0) begin
            errors++; $display("FAIL reset_outputs got %b want 0000000",
                {motor_l_en, motor_r_en, motor_l_dir, motor_r_dir, move_complete, move_error, busy});
        end
        load(6'd14);
        checks++;
        if (maze_state !== 6'd14 || heading !== 2'd0 || busy !== 1'b0 || motor_l_en !== 1'b0 || motor_r_en !== 1'b0) begin
            errors++; $display("FAIL load_start got maze=%0d hd=%0d busy=%b want 14/0/0", maze_state, heading, busy);
        end
    endtask

    task automatic test_north();
        load(6'd14);
        do_move(6'd8, -1);
        checks++;
        if (m_lat !== 10 || m_done !== 1'b1) begin
            errors++; $display("FAIL north_latency got %0d done=%b want 10/1", m_lat, m_done);
        end
        checks++;
        if (m_fwd !== 8 || m_right !== 0 || m_left !== 0 || m_other !== 0) begin
            errors++; $display("FAIL north_motors got f%0d r%0d l%0d o%0d want f8 r0 l0 o0", m_fwd, m_right, m_left, m_other);
        end
        checks++;
        if (m_maze !== 6'd8 || heading !== 2'd0 || m_busy_after !== 1'b0) begin
            errors++; $display("FAIL north_state got maze=%0d hd=%0d busy=%b want 8/0/0", m_maze, heading, m_busy_after);
        end
    endtask

    task automatic test_east_then_south();
        load(6'd14);
        do_move(6'd15, -1);
        checks++;
        if (m_lat !== 14 || m_right !== 4 || m_fwd !== 8 || m_left !== 0 || m_other !== 0) begin
            errors++; $display("FAIL east_move got lat=%0d r%0d f%0d l%0d o%0d want 14 r4 f8 l0 o0", m_lat, m_right, m_fwd, m_left, m_other);
        end
        checks++;
        if (m_maze !== 6'd15 || heading !== 2'd1) begin
            errors++; $display("FAIL east_state got maze=%0d hd=%0d want 15/1", m_maze, heading);
        end
        do_move(6'd21, -1);
        checks++;
        if (m_lat !== 14 || m_right !== 4 || m_fwd !== 8 || m_maze !== 6'd21 || heading !== 2'd2) begin
            errors++; $display("FAIL east_to_south got lat=%0d r%0d f%0d maze=%0d hd=%0d want 14 r4 f8 21 2", m_lat, m_right, m_fwd, m_maze, heading);
        end
    endtask

    task automatic test_half_turn_and_left();
        load(6'd14);
        do_move(6'd20, -1);
        checks++;
        if (m_lat !== 18 || m_right !== 8 || m_fwd !== 8 || m_left !== 0 || m_maze !== 6'd20 || heading !== 2'd2) begin
            errors++; $display("FAIL south_half_turn got lat=%0d r%0d f%0d l%0d maze=%0d hd=%0d want 18 r8 f8 l0 20 2", m_lat, m_right, m_fwd, m_left, m_maze, heading);
        end
        load(6'd14);
        do_move(6'd13, -1);
        checks++;
        if (m_lat !== 14 || m_left !== 4 || m_fwd !== 8 || m_right !== 0 || m_maze !== 6'd13 || heading !== 2'd3) begin
            errors++; $display("FAIL west_left_turn got lat=%0d l%0d f%0d r%0d maze=%0d hd=%0d want 14 l4 f8 r0 13 3", m_lat, m_left, m_fwd, m_right, m_maze, heading);
        end
    endtask

    task automatic test_same_cell();
        load(6'd14);
        do_move(6'd14, -1);
        checks++;
        if (m_lat !== 2 || m_done !== 1'b1 || m_err !== 1'b0 || (m_fwd + m_right + m_left + m_other) !== 0 || m_maze !== 6'd14) begin
            errors++; $display("FAIL same_cell got lat=%0d done=%b err=%b motors=%0d maze=%0d want 2 1 0 0 14", m_lat, m_done, m_err, m_fwd + m_right + m_left + m_other, m_maze);
        end
    endtask

    task automatic test_invalid();
        load(6'd13);
        do_move(6'd13, -1);
        do_move(6'd14, -1);
        do_move(6'd13, -1);
        // Heading is now W (back west from 14), so an error must leave it at 3.
        do_move(6'd40, -1);
        checks++;
        if (m_lat !== 2 || m_err !== 1'b1 || m_done !== 1'b0 || m_maze !== 6'd13 || heading !== 2'd3 || (m_fwd + m_right + m_left + m_other) !== 0) begin
            errors++; $display("FAIL err_out_of_range got lat=%0d err=%b done=%b maze=%0d hd=%0d want 2 1 0 13 3", m_lat, m_err, m_done, m_maze, heading);
        end
        load(6'd17);
        do_move(6'd18, -1);
        checks++;
        if (m_lat !== 2 || m_err !== 1'b1 || m_done !== 1'b0 || m_maze !== 6'd17 || (m_fwd + m_right + m_left + m_other) !== 0) begin
            errors++; $display("FAIL err_row_wrap got lat=%0d err=%b done=%b maze=%0d want 2 1 0 17", m_lat, m_err, m_done, m_maze);
        end
        load(6'd14);
        do_move(6'd21, -1);
        checks++;
        if (m_lat !== 2 || m_err !== 1'b1 || m_done !== 1'b0 || m_maze !== 6'd14 || m_busy_after !== 1'b0 || (m_fwd + m_right + m_left + m_other) !== 0) begin
            errors++; $display("FAIL err_non_adjacent got lat=%0d err=%b done=%b maze=%0d busy=%b want 2 1 0 14 0", m_lat, m_err, m_done, m_maze, m_busy_after);
        end
    endtask

    task automatic test_ignore_during_drive();
        load(6'd14);
        do_move(6'd8, 5);
        checks++;
        if (m_lat !== 10 || m_fwd !== 8 || m_maze !== 6'd8 || m_busy_after !== 1'b0) begin
            errors++; $display("FAIL ignore_in_drive got lat=%0d f%0d maze=%0d busy=%b want 10 f8 8 0", m_lat, m_fwd, m_maze, m_busy_after);
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || maze_state !== 6'd8) begin
            errors++; $display("FAIL ignore_no_queue got busy=%b maze=%0d want 0/8", busy, maze_state);
        end
    endtask

    task automatic test_load_priority();
        load(6'd14);
        load_start  = 1'b1; start_state = 6'd22;
        timer_start = 1'b1; next_state  = 6'd23;
        tick();
        load_start = 1'b0; timer_start = 1'b0;
        checks++;
        if (maze_state !== 6'd22 || busy !== 1'b0 || heading !== 2'd0) begin
            errors++; $display("FAIL load_priority got maze=%0d busy=%b hd=%0d want 22/0/0", maze_state, busy, heading);
        end
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || maze_state !== 6'd22 || motor_l_en !== 1'b0) begin
            errors++; $display("FAIL load_timer_dropped got busy=%b maze=%0d len=%b want 0/22/0", busy, maze_state, motor_l_en);
        end
    endtask

    task automatic test_reset_mid_drive();
        logic saw_complete;
        load(6'd14);
        next_state = 6'd8; timer_start = 1'b1;
        tick();
        timer_start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (motor_l_en !== 1'b1 || motor_r_en !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_drive_active got len=%b ren=%b busy=%b want 1/1/1", motor_l_en, motor_r_en, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({motor_l_en, motor_r_en, motor_l_dir, motor_r_dir} !== 4'd0 || maze_state !== 6'd0 || busy !== 1'b0 || heading !== 2'd0) begin
            errors++; $display("FAIL reset_mid_drive got mot=%b maze=%0d busy=%b hd=%0d want 0000/0/0/0",
                {motor_l_en, motor_r_en, motor_l_dir, motor_r_dir}, maze_state, busy, heading);
        end
        saw_complete = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (move_complete) saw_complete = 1'b1;
            tick();
        end
        checks++;
        if (saw_complete !== 1'b0) begin
            errors++; $display("FAIL reset_no_complete got %b want 0", saw_complete);
        end
    endtask

    initial begin
        test_reset();
        test_north();
        test_east_then_south();
        test_half_turn_and_left();
        test_same_cell();
        test_invalid();
        test_ignore_during_drive();
        test_load_priority();
        test_reset_mid_drive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
